// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: 32-cycle shift-add multiplier and restoring divider.
// Define MULDIV_DIV_EN to include the divider; without it, divide ops finish at once as illegal.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_h,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        write,
    output logic        illegal
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]  state;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [63:0] acc_step;
    logic [31:0] operand_b;
    logic [2:0]  op_q;
    logic        neg_q;
    logic        special_q;
    logic        illegal_q;
    logic [31:0] result_q;
    logic [4:0]  rd_q;

    logic        a_signed;
    logic        b_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        neg_in;
    logic        special_in;
    logic        illegal_in;
    logic [31:0] special_val;

    // Operand magnitudes and the sign to restore once the unsigned core finishes
    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed && rs1_data[31];
        b_neg    = b_signed && rs2_data[31];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
        neg_in   = (funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
    end

`ifdef MULDIV_DIV_EN
    always_comb begin
        special_in  = funct3[2] && ((rs2_data == 32'd0) ||
                      (!funct3[0] && rs1_data == 32'h8000_0000 && rs2_data == 32'hFFFF_FFFF));
        illegal_in  = 1'b0;
        if (rs2_data == 32'd0)
            special_val = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
        else
            special_val = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
`else
    always_comb begin
        special_in  = funct3[2];
        illegal_in  = funct3[2];
        special_val = 32'd0;
    end
`endif

    logic [32:0] add_sum;
`ifdef MULDIV_DIV_EN
    logic [33:0] sub_diff;
`endif

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        add_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand_b} : 33'd0);
        acc_step = {add_sum, acc[31:1]};
`ifdef MULDIV_DIV_EN
        sub_diff = {1'b0, acc[63:31]} - {2'b00, operand_b};
        if (op_q[2])
            acc_step = sub_diff[33] ? {acc[62:0], 1'b0} : {sub_diff[31:0], acc[30:0], 1'b1};
`endif
    end

    logic [63:0] prod_neg;
    logic [31:0] mul_val;
    logic [31:0] div_sel;
    logic [31:0] div_val;
    logic [31:0] formed;

    always_comb begin
        prod_neg = -acc;
        if (op_q[1:0] != 2'b00)
            mul_val = neg_q ? prod_neg[63:32] : acc[63:32];
        else
            mul_val = neg_q ? prod_neg[31:0] : acc[31:0];
        div_sel = op_q[1] ? acc[63:32] : acc[31:0];
        div_val = neg_q ? -div_sel : div_sel;
        if (special_q)
            formed = acc[31:0];
        else if (op_q[2])
            formed = div_val;
        else
            formed = mul_val;
    end

    always_ff @(posedge clk) begin
        if (rst_h) begin
            state     <= IDLE;
            count     <= 5'd0;
            acc       <= 64'd0;
            operand_b <= 32'd0;
            op_q      <= 3'd0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= 32'd0;
            rd_q      <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= funct3;
                        rd_q      <= rd_in;
                        neg_q     <= neg_in;
                        operand_b <= b_mag;
                        count     <= 5'd0;
                        special_q <= special_in;
                        illegal_q <= illegal_in;
                        if (special_in) begin
                            acc   <= {32'd0, special_val};
                            state <= FINISH;
                        end else begin
                            acc   <= {32'd0, a_mag};
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_step;
                    count <= count + 5'd1;
                    if (count == 5'd31)
                        state <= FINISH;
                end
                FINISH: begin
                    result_q <= formed;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The signed result is formed while in FINISH and then held in result_q
    assign busy    = (state != IDLE);
    assign done    = (state == FINISH);
    assign write   = done && !illegal_q;
    assign illegal = done && illegal_q;
    assign result  = done ? formed : result_q;
    assign rd_out  = rd_q;

endmodule
